// File: rtl/param_shift_stream.sv
// -----------------------------------------------------------------------------
// param_shift_stream
//
// Parallel-load row shift register that streams its row out one element per
// accepted beat over a valid/ready handshake. The row can be recirculated for
// a programmable number of passes. On the final pass the tail is back-filled
// from SHIFT_IN so that several instances can be chained head-to-tail.
//
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   FLUSH                 synchronous abort back to IDLE (entries are kept)
//   LOAD_VALID/READY      load handshake for DATA_IN/PASSES
//   DATA_IN               row; element i at [DATA_W*i +: DATA_W], element 0 first out
//   PASSES                number of passes (0 is treated as 1)
//   SHIFT_IN              tail fill value used during the final pass
//   OUT_VALID/READY       output handshake
//   SHIFT_OUT             head element (entry DEPTH-1), combinational
//   OUT_LAST              current beat is the last element of a pass
//   DONE                  one-cycle pulse after the final beat is accepted
//   PASS_IDX              current pass index (0-based)
// -----------------------------------------------------------------------------
module param_shift_stream #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int PASS_W = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    FLUSH,
    input  logic                    LOAD_VALID,
    output logic                    LOAD_READY,
    input  logic [DATA_W*DEPTH-1:0] DATA_IN,
    input  logic [PASS_W-1:0]       PASSES,
    input  logic [DATA_W-1:0]       SHIFT_IN,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [DATA_W-1:0]       SHIFT_OUT,
    output logic                    OUT_LAST,
    output logic                    DONE,
    output logic [PASS_W-1:0]       PASS_IDX
);

    localparam int CNT_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [DEPTH-1:0][DATA_W-1:0]   entries_q, entries_d;
    logic [CNT_W-1:0]               elem_q, elem_d;
    logic [PASS_W-1:0]              pass_idx_q, pass_idx_d;
    logic [PASS_W-1:0]              passes_q, passes_d;
    logic                           done_q, done_d;

    logic                           last_elem;
    logic                           last_pass;

    assign last_elem = (elem_q == CNT_W'(DEPTH - 1));
    assign last_pass = (pass_idx_q == (passes_q - PASS_W'(1)));

    always_comb begin
        state_d    = state_q;
        entries_d  = entries_q;
        elem_d     = elem_q;
        pass_idx_d = pass_idx_q;
        passes_d   = passes_q;
        done_d     = 1'b0;

        if (FLUSH) begin
            // Abort wins over any beat or load in the same cycle; the row
            // contents are deliberately left untouched.
            state_d    = IDLE;
            elem_d     = '0;
            pass_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (LOAD_VALID) begin
                        // Reverse the element order so element 0 sits at the head.
                        for (int i = 0; i < DEPTH; i++) begin
                            entries_d[DEPTH-1-i] = DATA_IN[DATA_W*i +: DATA_W];
                        end
                        passes_d   = (PASSES == '0) ? PASS_W'(1) : PASSES;
                        elem_d     = '0;
                        pass_idx_d = '0;
                        state_d    = STREAM;
                    end
                end
                STREAM: begin
                    if (OUT_READY) begin
                        for (int k = 0; k < DEPTH - 1; k++) begin
                            entries_d[k+1] = entries_q[k];
                        end
                        // Recirculate the head until the final pass, then
                        // take the chained neighbour's data instead.
                        entries_d[0] = last_pass ? SHIFT_IN : entries_q[DEPTH-1];

                        if (last_elem) begin
                            elem_d = '0;
                            if (last_pass) begin
                                state_d    = IDLE;
                                done_d     = 1'b1;
                                pass_idx_d = '0;
                            end else begin
                                pass_idx_d = pass_idx_q + PASS_W'(1);
                            end
                        end else begin
                            elem_d = elem_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            entries_q  <= '0;
            elem_q     <= '0;
            pass_idx_q <= '0;
            passes_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            entries_q  <= entries_d;
            elem_q     <= elem_d;
            pass_idx_q <= pass_idx_d;
            passes_q   <= passes_d;
            done_q     <= done_d;
        end
    end

    assign LOAD_READY = (state_q == IDLE);
    assign OUT_VALID  = (state_q == STREAM);
    assign OUT_LAST   = (state_q == STREAM) && last_elem;
    assign SHIFT_OUT  = entries_q[DEPTH-1];
    assign DONE       = done_q;
    assign PASS_IDX   = pass_idx_q;

endmodule
